insn_decode_stage: RTL and testbench

//  Pipelined instruction decode stage for the 16-bit SIWO core; the consuming end of the ISA encoding.

---
 rtl/insn_decode_stage.sv | 153 +++++++++++++++
 tb/tb_insn_decode_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_decode_stage.sv
// Decode stage for the 16-bit SIWO core: registers one decoded beat per accepted fetch word
// and parks the front end in HALTED after a HLT or an illegal encoding until resume.
module insn_decode_stage #(
    parameter int unsigned DROP_NOP = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_insn,
    input  logic [15:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_kind,
    output logic [3:0]  out_reg_a,
    output logic [3:0]  out_reg_b,
    output logic [4:0]  out_func,
    output logic [15:0] out_immd,
    output logic        out_relative,
    output logic        out_immd_sel,
    output logic [15:0] out_pc,
    input  logic        resume,
    output logic        halted,
    output logic [15:0] decode_count
);

    localparam logic [2:0] KIND_SET     = 3'd0;
    localparam logic [2:0] KIND_OP      = 3'd1;
    localparam logic [2:0] KIND_JUMP    = 3'd2;
    localparam logic [2:0] KIND_BRANCH  = 3'd3;
    localparam logic [2:0] KIND_HALT    = 3'd4;
    localparam logic [2:0] KIND_NOP     = 3'd5;
    localparam logic [2:0] KIND_ILLEGAL = 3'd6;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    localparam logic [4:0] FUNC_MAX = 5'b10001;

    typedef struct packed {
        logic [2:0]  kind;
        logic [3:0]  reg_a;
        logic [3:0]  reg_b;
        logic [4:0]  func;
        logic [15:0] immd;
        logic        relative;
        logic        immd_sel;
        logic [15:0] pc;
    } beat_t;

    logic [0:0]  state_q, state_d;
    logic        out_valid_q, out_valid_d;
    beat_t       beat_q, beat_d;
    logic [15:0] count_q, count_d;

    beat_t       dec;
    logic        accept;
    logic        drain;
    logic        drop_nop;
    logic        load;
    logic        stops_front_end;

    // Combinational decode of the incoming word; fields not owned by a kind stay zero.
    always_comb begin
        dec      = '0;
        dec.kind = KIND_ILLEGAL;
        dec.pc   = in_pc;
        if (in_insn[15]) begin
            dec.kind  = KIND_SET;
            dec.reg_a = in_insn[14:11];
            dec.immd  = {6'b0, in_insn[9:0]};
        end else if (in_insn[14]) begin
            dec.kind     = in_insn[13] ? KIND_BRANCH : KIND_JUMP;
            dec.relative = in_insn[12];
            dec.immd_sel = in_insn[11];
            if (in_insn[11]) begin
                dec.immd = in_insn[12] ? {{5{in_insn[10]}}, in_insn[10:0]}
                                       : {5'b0, in_insn[10:0]};
            end else begin
                dec.reg_b = in_insn[7:4];
                dec.reg_a = in_insn[3:0];
            end
        end else if (in_insn[13]) begin
            if (in_insn[4:0] <= FUNC_MAX) begin
                dec.kind  = KIND_OP;
                dec.reg_a = in_insn[12:9];
                dec.reg_b = in_insn[8:5];
                dec.func  = in_insn[4:0];
            end
        end else if (in_insn == 16'h0000) begin
            dec.kind = KIND_HALT;
        end else if (in_insn == 16'h0001) begin
            dec.kind = KIND_NOP;
        end
    end

    assign in_ready        = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept          = in_valid && in_ready;
    assign drain           = out_valid_q && out_ready;
    assign drop_nop        = (DROP_NOP != 0) && (dec.kind == KIND_NOP);
    assign load            = accept && !drop_nop;
    assign stops_front_end = (dec.kind == KIND_HALT) || (dec.kind == KIND_ILLEGAL);

    // A dropped NOP still counts as accepted, so a concurrent drain must clear out_valid.
    always_comb begin
        out_valid_d = out_valid_q;
        beat_d      = beat_q;
        if (load) begin
            out_valid_d = 1'b1;
            beat_d      = dec;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (accept && stops_front_end) state_d = ST_HALTED;
            ST_HALTED: if (resume) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    assign count_d = count_q + {15'b0, drain};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            beat_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            beat_q      <= beat_d;
            count_q     <= count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_kind     = beat_q.kind;
    assign out_reg_a    = beat_q.reg_a;
    assign out_reg_b    = beat_q.reg_b;
    assign out_func     = beat_q.func;
    assign out_immd     = beat_q.immd;
    assign out_relative = beat_q.relative;
    assign out_immd_sel = beat_q.immd_sel;
    assign out_pc       = beat_q.pc;
    assign halted       = (state_q == ST_HALTED);
    assign decode_count = count_q;

endmodule

// File: tb/tb_insn_decode_stage.sv
// Self-checking bench for insn_decode_stage: directed vector table, hand-written
// backpressure/halt/reset sequences, then randomized traffic against a queue scoreboard.
module tb_insn_decode_stage;

    typedef struct packed {
        logic [2:0]  kind;
        logic [3:0]  reg_a;
        logic [3:0]  reg_b;
        logic [4:0]  func;
        logic [15:0] immd;
        logic        relative;
        logic        immd_sel;
        logic [15:0] pc;
    } beat_t;

    typedef struct {
        logic [15:0] insn;
        logic [15:0] pc;
        logic        beat;
        logic        halts;
        beat_t       exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_insn;
    logic [15:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_kind;
    logic [3:0]  out_reg_a;
    logic [3:0]  out_reg_b;
    logic [4:0]  out_func;
    logic [15:0] out_immd;
    logic        out_relative;
    logic        out_immd_sel;
    logic [15:0] out_pc;
    logic        resume;
    logic        halted;
    logic [15:0] decode_count;

    beat_t       dut_beat;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    insn_decode_stage #(.DROP_NOP(1)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_reg_a(out_reg_a), .out_reg_b(out_reg_b),
        .out_func(out_func), .out_immd(out_immd), .out_relative(out_relative),
        .out_immd_sel(out_immd_sel), .out_pc(out_pc),
        .resume(resume), .halted(halted), .decode_count(decode_count)
    );

    always_comb dut_beat = {out_kind, out_reg_a, out_reg_b, out_func, out_immd,
                            out_relative, out_immd_sel, out_pc};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    function automatic beat_t mk(input int unsigned kind, input int unsigned a, input int unsigned b,
                                 input int unsigned f, input int unsigned immd, input int unsigned rel,
                                 input int unsigned sel, input int unsigned pc);
        beat_t r;
        r.kind = 3'(kind); r.reg_a = 4'(a); r.reg_b = 4'(b); r.func = 5'(f);
        r.immd = 16'(immd); r.relative = 1'(rel); r.immd_sel = 1'(sel); r.pc = 16'(pc);
        return r;
    endfunction

    // Reference decoder from the ISA rules, using integer field arithmetic.
    function automatic beat_t ref_decode(input logic [15:0] w, input logic [15:0] pc);
        int unsigned v = w;
        int unsigned off;
        int unsigned f;
        if (v >= 32768)
            return mk(0, (v / 2048) % 16, 0, 0, v % 1024, 0, 0, pc);
        if (v >= 16384) begin
            if ((v / 2048) % 2 == 1) begin
                off = v % 2048;
                if ((v / 4096) % 2 == 1 && off >= 1024) off = off + 63488;
                return mk(((v / 8192) % 2 == 1) ? 3 : 2, 0, 0, 0, off, (v / 4096) % 2, 1, pc);
            end
            return mk(((v / 8192) % 2 == 1) ? 3 : 2, v % 16, (v / 16) % 16, 0, 0, (v / 4096) % 2, 0, pc);
        end
        if (v >= 8192) begin
            f = v % 32;
            if (f > 17) return mk(6, 0, 0, 0, 0, 0, 0, pc);
            return mk(1, (v / 512) % 16, (v / 32) % 16, f, 0, 0, 0, pc);
        end
        if (v == 0) return mk(4, 0, 0, 0, 0, 0, 0, pc);
        if (v == 1) return mk(5, 0, 0, 0, 0, 0, 0, pc);
        return mk(6, 0, 0, 0, 0, 0, 0, pc);
    endfunction

    vec_t        vecs[$];
    beat_t       q[$];
    beat_t       d;
    logic        m_halted;
    logic [15:0] m_count;
    logic [15:0] exp_count;
    logic        exp_rdy;
    logic        hs;
    logic        acc;

    initial begin
        vecs.push_back('{16'hA3FF, 16'h0010, 1'b1, 1'b0, mk(0, 4, 0, 0, 16'h03FF, 0, 0, 16'h0010)});
        vecs.push_back('{16'h2461, 16'h0012, 1'b1, 1'b0, mk(1, 2, 3, 1, 0, 0, 0, 16'h0012)});
        vecs.push_back('{16'h7FFF, 16'h0014, 1'b1, 1'b0, mk(3, 0, 0, 0, 16'hFFFF, 1, 1, 16'h0014)});
        vecs.push_back('{16'h4FFF, 16'h0016, 1'b1, 1'b0, mk(2, 0, 0, 0, 16'h07FF, 0, 1, 16'h0016)});
        vecs.push_back('{16'h57FF, 16'h0018, 1'b1, 1'b0, mk(2, 15, 15, 0, 0, 1, 0, 16'h0018)});
        vecs.push_back('{16'h6053, 16'h001A, 1'b1, 1'b0, mk(3, 3, 5, 0, 0, 0, 0, 16'h001A)});
        vecs.push_back('{16'h0001, 16'h001C, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{16'h0000, 16'h001E, 1'b1, 1'b1, mk(4, 0, 0, 0, 0, 0, 0, 16'h001E)});
        vecs.push_back('{16'h2012, 16'h0020, 1'b1, 1'b1, mk(6, 0, 0, 0, 0, 0, 0, 16'h0020)});
        vecs.push_back('{16'h0002, 16'h0022, 1'b1, 1'b1, mk(6, 0, 0, 0, 0, 0, 0, 16'h0022)});
        vecs.push_back('{16'h2231, 16'h0024, 1'b1, 1'b0, mk(1, 1, 1, 17, 0, 0, 0, 16'h0024)});
        vecs.push_back('{16'h87FF, 16'h0026, 1'b1, 1'b0, mk(0, 0, 0, 0, 16'h03FF, 0, 0, 16'h0026)});
        vecs.push_back('{16'h7C00, 16'h0028, 1'b1, 1'b0, mk(3, 0, 0, 0, 16'hFC00, 1, 1, 16'h0028)});

        reset = 1'b1; in_valid = 1'b0; in_insn = '0; in_pc = '0; out_ready = 1'b0; resume = 1'b0;
        repeat (2) @(posedge clock);
        smp();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));
        chk("rst_count", 64'(decode_count), 64'(0));
        chk("rst_fields", 64'(dut_beat), 64'(0));
        step();
        reset = 1'b0;
        exp_count = '0;

        foreach (vecs[i]) begin
            in_valid = 1'b1; in_insn = vecs[i].insn; in_pc = vecs[i].pc; out_ready = 1'b1;
            smp();
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(1));
            step();
            in_valid = 1'b0;
            smp();
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].beat));
            if (vecs[i].beat) begin
                chk($sformatf("v%0d_beat", i), 64'(dut_beat), 64'(vecs[i].exp));
                exp_count++;
            end
            chk($sformatf("v%0d_halted", i), 64'(halted), 64'(vecs[i].halts));
            if (vecs[i].halts) begin
                chk($sformatf("v%0d_ready_halted", i), 64'(in_ready), 64'(0));
                step();
                resume = 1'b1;
                smp();
                chk($sformatf("v%0d_still_halted", i), 64'(halted), 64'(1));
                step();
                resume = 1'b0;
                smp();
                chk($sformatf("v%0d_resumed", i), 64'(halted), 64'(0));
                chk($sformatf("v%0d_ready_resumed", i), 64'(in_ready), 64'(1));
            end
            step();
        end
        smp();
        chk("table_count", 64'(decode_count), 64'(exp_count));

        // Backpressure: first beat must hold while a second word waits.
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_insn = 16'hA3FF; in_pc = 16'h0040;
        smp();
        chk("bp_first_ready", 64'(in_ready), 64'(1));
        step();
        in_insn = 16'h2461; in_pc = 16'h0042;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk($sformatf("bp_stall%0d_ready", k), 64'(in_ready), 64'(0));
            chk($sformatf("bp_stall%0d_beat", k), 64'(dut_beat), 64'(mk(0, 4, 0, 0, 16'h03FF, 0, 0, 16'h0040)));
            step();
        end
        out_ready = 1'b1;
        smp();
        chk("bp_release_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        smp();
        chk("bp_second_valid", 64'(out_valid), 64'(1));
        chk("bp_second_beat", 64'(dut_beat), 64'(mk(1, 2, 3, 1, 0, 0, 0, 16'h0042)));
        step();
        exp_count = exp_count + 16'd2;
        smp();
        chk("bp_drained", 64'(out_valid), 64'(0));
        chk("bp_count", 64'(decode_count), 64'(exp_count));
        in_valid = 1'b1; in_insn = 16'h0001; in_pc = 16'h0044;
        smp();
        chk("nop_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        smp();
        chk("nop_dropped", 64'(out_valid), 64'(0));
        chk("nop_count", 64'(decode_count), 64'(exp_count));

        // HALT with the next fetch word held valid the whole time.
        step();
        in_valid = 1'b1; in_insn = 16'h0000; in_pc = 16'h0050;
        step();
        in_insn = 16'hA3FF; in_pc = 16'h0052;
        smp();
        chk("halt_halted", 64'(halted), 64'(1));
        chk("halt_ready", 64'(in_ready), 64'(0));
        chk("halt_kind", 64'(out_kind), 64'(4));
        step();
        smp();
        chk("halt_hold_ready", 64'(in_ready), 64'(0));
        chk("halt_drained", 64'(out_valid), 64'(0));
        step();
        resume = 1'b1;
        smp();
        chk("halt_resume_same_cycle", 64'(in_ready), 64'(0));
        step();
        resume = 1'b0;
        smp();
        chk("halt_resumed_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        smp();
        chk("halt_next_beat", 64'(dut_beat), 64'(mk(0, 4, 0, 0, 16'h03FF, 0, 0, 16'h0052)));
        step();
        exp_count = exp_count + 16'd2;
        smp();
        chk("halt_count", 64'(decode_count), 64'(exp_count));

        // Reset with a pending beat and a simultaneous resume.
        step();
        out_ready = 1'b0; in_valid = 1'b1; in_insn = 16'h0000; in_pc = 16'h0060;
        step();
        in_valid = 1'b0;
        smp();
        chk("mid_pending", 64'(out_valid), 64'(1));
        reset = 1'b1; resume = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0; resume = 1'b0;
        smp();
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_halted", 64'(halted), 64'(0));
        chk("mid_rst_count", 64'(decode_count), 64'(0));

        // Randomized traffic against a queue scoreboard.
        step();
        m_halted = 1'b0; m_count = '0;
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            resume = ($urandom_range(0, 4) == 0);
            in_insn = ($urandom_range(0, 9) == 0) ? 16'h0001 : 16'($urandom);
            in_pc = 16'($urandom);
            smp();
            exp_rdy = !m_halted && (q.size() == 0 || out_ready);
            chk("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("rnd_halted", 64'(halted), 64'(m_halted));
            chk("rnd_out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("rnd_count", 64'(decode_count), 64'(m_count));
            if (q.size() != 0) chk("rnd_beat", 64'(dut_beat), 64'(q[0]));
            hs = (q.size() != 0) && out_ready;
            acc = in_valid && exp_rdy;
            d = ref_decode(in_insn, in_pc);
            step();
            if (hs) begin
                void'(q.pop_front());
                m_count = m_count + 16'd1;
            end
            if (acc) begin
                if (d.kind != 3'd5) q.push_back(d);
                if (d.kind == 3'd4 || d.kind == 3'd6) m_halted = 1'b1;
            end else if (m_halted && resume) begin
                m_halted = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
